arb_req_tracker: RTL and testbench
==================================

Name: arb_req_tracker

Overview:
- Upstream stage of single_cycle_arbiter. Collects per-requester request pulses from N sources and holds a saturating pending count for each source.
- Drives `req_o` (one bit per source with pending work) into the arbiter's `req_i`.
- Consumes the arbiter's `gnt_o` as `gnt_i` and retires one pending request per grant.
- Flags overflow and illegal grants with sticky error bits.

Parameters:
- N, 16, number of requesters; must match arbiter N.
- CNT_W, 4, width of each pending counter; max count is 2^CNT_W-1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- push_i  in  N  single-cycle request pulses, one bit per source; multiple bits may be high together.
- gnt_i  in  N  grant vector from the arbiter; legal values are one-hot or zero.
- clr_err_i  in  1  synchronous clear of all sticky error flags.
- req_o  out  N  bit i = (cnt[i] != 0); feeds the arbiter's req_i.
- ovf_o  out  N  sticky per-source overflow flag.
- gnt_err_o  out  1  sticky illegal-grant flag.
- idle_o  out  1  high when all counters are zero.

Behaviour:
- Reset, asynchronous on the falling edge of `reset`:
  - all cnt = 0
  - req_o = 0
  - ovf_o = 0
  - gnt_err_o = 0
  - idle_o = 1
  - Release is synchronous to clk, handled externally.
- Outputs are decoded combinationally from registers only:
  - req_o[i] = |cnt[i]
  - idle_o = ~|req_o
  - No input-to-output combinational path.
- Grant legality, evaluated each cycle:
  - gnt_ok = gnt_i is onehot0 AND (gnt_i & ~req_o) == 0
  - eff_gnt = gnt_ok ? gnt_i : 0
- Per-source counter update at each clk edge, case (push_i[i], eff_gnt[i]):
  - 0,0: hold.
  - 1,0: if cnt < max then cnt+1; else hold and set ovf_o[i].
  - 0,1: cnt-1. eff_gnt never targets cnt==0, so no underflow.
  - 1,1: hold. Net zero change; no overflow even at max.
- Latency:
  - push at edge t makes req_o visible after edge t (one cycle).
  - grant at edge t makes the decrement visible after edge t.
  - Back-to-back grants on the same source are legal while cnt > 0.
- Illegal grant (multi-hot, or any grant bit where req_o is 0):
  - The entire grant vector is ignored; no counter is decremented.
  - gnt_err_o is set at the next edge.
  - Pushes in that cycle still apply.
- clr_err_i = 1 at an edge clears ovf_o and gnt_err_o.
  - If a new error occurs in the same cycle, set wins.
  - Counters are unaffected.
- Reset mid-operation: all pending counts are discarded and req_o drops immediately (asynchronous).

Decomposition:
- Package arb_pkg:
  - default N and CNT_W constants.
  - function onehot0(vec), true if at most one bit is set.
  - typedef cnt_t = logic [CNT_W-1:0].
- Sub-module arb_req_cnt holds one requester's slice:
  - saturating up/down counter, ovf flag, req bit.
  - Ports: clk, reset, push, gnt, clr, req, ovf.
- Top level generates N instances and owns the grant-legality logic and gnt_err_o.

Test Plan:
- Reset: drive reset=0 while push_i=16'hFFFF -> req_o=0 and idle_o=1 throughout; after release with push_i=0, all counts stay 0.
- Basic flow: pulse push_i=16'h0005 for 1 cycle -> next cycle req_o=16'h0005, idle_o=0; gnt_i=16'h0001 for 1 cycle -> req_o=16'h0004; gnt_i=16'h0004 -> req_o=0, idle_o=1.
- Saturation: push_i[3]=1 for 16 consecutive cycles with CNT_W=4 -> cnt[3]=15 and ovf_o[3]=1 after the 16th edge; then 15 grants on bit 3 -> req_o[3]=0 exactly after the 15th.
- Simultaneous push and grant on source 7 at cnt=15 -> cnt stays 15, ovf_o[7] stays 0; at cnt=1 -> cnt stays 1, req_o[7] stays 1.
- Illegal grant: cnt[2]=1, cnt[5]=1, gnt_i=16'h0024 -> gnt_err_o=1, both counts unchanged; then gnt_i=16'h0100 (req_o[8]=0) -> no change, gnt_err_o stays 1; clr_err_i=1 -> gnt_err_o=0.
- Arbiter closed loop: connect to single_cycle_arbiter with N=16, push 3 requests on each of sources 0, 9, 15 -> exactly 9 grants total, each source granted 3 times, gnt_err_o=0, idle_o=1 at the end.

Source files
------------

// File: rtl/arb_req_tracker_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the arbiter request tracker:
//   N_DEF, CNT_W_DEF : default requester count and pending-counter width
//   ONEHOT_W         : widest grant vector onehot0() accepts (zero-extend)
//   cnt_t            : pending-counter type at the default width
//   onehot0(vec)     : true when at most one bit of vec is set
// -----------------------------------------------------------------------------
package arb_pkg;

    localparam int N_DEF     = 16;
    localparam int CNT_W_DEF = 4;
    localparam int ONEHOT_W  = 64;

    typedef logic [CNT_W_DEF-1:0] cnt_t;

    // Clearing the lowest set bit leaves zero only for zero or one-hot input.
    function automatic logic onehot0(input logic [ONEHOT_W-1:0] vec);
        return ((vec & (vec - ONEHOT_W'(1))) == ONEHOT_W'(0));
    endfunction

endpackage

// File: rtl/arb_req_tracker_cnt.sv
// -----------------------------------------------------------------------------
// arb_req_cnt
// One requester's slice: saturating pending counter, sticky overflow flag and
// the derived request bit.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   push  : request pulse for this source
//   gnt   : already-qualified (legal) grant for this source
//   clr   : synchronous clear of the sticky overflow flag
//   req   : pending count is non-zero
//   ovf   : sticky overflow flag
// -----------------------------------------------------------------------------
module arb_req_cnt
    import arb_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic gnt,
    input  logic clr,
    output logic req,
    output logic ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ovf_q;
    logic             ovf_d;

    // Next-state: clear first so that a same-cycle overflow wins over clr.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q & ~clr;
        case ({push, gnt})
            2'b10: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            2'b01: begin
                // Qualified grants never hit an empty counter; guard anyway.
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                // Idle or push+grant together: net zero, no overflow.
                cnt_d = cnt_q;
            end
        endcase
    end

    // Counter and overflow state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= CNT_ZERO;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign req = (cnt_q != CNT_ZERO);
    assign ovf = ovf_q;

endmodule

// File: rtl/arb_req_tracker.sv
// -----------------------------------------------------------------------------
// arb_req_tracker
// Collects per-source request pulses into saturating pending counters and
// retires one pending request per legal arbiter grant.
//   clk       : rising-edge clock
//   reset     : asynchronous active-low reset
//   push_i    : request pulses, one bit per source (multi-hot allowed)
//   gnt_i     : arbiter grant vector (legal: one-hot or zero, pending only)
//   clr_err_i : synchronous clear of all sticky error flags
//   req_o     : per-source "work pending", feeds the arbiter req_i
//   ovf_o     : sticky per-source overflow flags
//   gnt_err_o : sticky illegal-grant flag
//   idle_o    : no source has pending work
// All outputs decode from registers only.
// -----------------------------------------------------------------------------
module arb_req_tracker
    import arb_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] push_i,
    input  logic [N-1:0] gnt_i,
    input  logic         clr_err_i,
    output logic [N-1:0] req_o,
    output logic [N-1:0] ovf_o,
    output logic         gnt_err_o,
    output logic         idle_o
);

    logic [ONEHOT_W-1:0] gnt_ext_s;
    logic                gnt_ok_s;
    logic [N-1:0]        eff_gnt_s;
    logic                gnt_err_q;
    logic                gnt_err_d;

    // Grant legality: an illegal vector is dropped as a whole.
    always_comb begin
        gnt_ext_s        = {ONEHOT_W{1'b0}};
        gnt_ext_s[N-1:0] = gnt_i;
        gnt_ok_s         = onehot0(gnt_ext_s) && ((gnt_i & ~req_o) == {N{1'b0}});
        if (gnt_ok_s) begin
            eff_gnt_s = gnt_i;
        end else begin
            eff_gnt_s = {N{1'b0}};
        end
        gnt_err_d = ~gnt_ok_s | (gnt_err_q & ~clr_err_i);
    end

    // Sticky illegal-grant flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_err_q <= 1'b0;
        end else begin
            gnt_err_q <= gnt_err_d;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_src
        arb_req_cnt #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .reset (reset),
            .push  (push_i[i]),
            .gnt   (eff_gnt_s[i]),
            .clr   (clr_err_i),
            .req   (req_o[i]),
            .ovf   (ovf_o[i])
        );
    end

    assign gnt_err_o = gnt_err_q;
    assign idle_o    = ~|req_o;

endmodule

// File: tb/tb_arb_req_tracker.sv
module tb_arb_req_tracker;

    typedef struct packed {
        logic [15:0] req;
        logic [15:0] ovf;
        logic        err;
        logic        idle;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] push_i = 16'h0000;
    logic [15:0] gnt_i = 16'h0000;
    logic        clr_err_i = 1'b0;
    logic [15:0] req_o;
    logic [15:0] ovf_o;
    logic        gnt_err_o;
    logic        idle_o;

    int total = 0;
    int bad   = 0;

    // Reference model: plain integer pending counts per source.
    int          cnt_m [16];
    logic [15:0] ovf_m = 16'h0000;
    logic        err_m = 1'b0;
    exp_t        exp_q [$];

    arb_req_tracker #(.N(16), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .push_i    (push_i),
        .gnt_i     (gnt_i),
        .clr_err_i (clr_err_i),
        .req_o     (req_o),
        .ovf_o     (ovf_o),
        .gnt_err_o (gnt_err_o),
        .idle_o    (idle_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.req = 16'h0000;
        for (int i = 0; i < 16; i++) e.req[i] = (cnt_m[i] != 0);
        e.ovf  = ovf_m;
        e.err  = err_m;
        e.idle = (e.req == 16'h0000);
        return e;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) cnt_m[i] = 0;
        ovf_m = 16'h0000;
        err_m = 1'b0;
    endfunction

    function automatic void model_step(input logic [15:0] p, input logic [15:0] g, input logic c);
        int  nset = 0;
        logic ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (g[i]) begin
                nset++;
                if (cnt_m[i] == 0) ok = 1'b0;
            end
        end
        if (nset > 1) ok = 1'b0;
        if (c) ovf_m = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            logic gi;
            gi = g[i] & ok;
            if (p[i] && !gi) begin
                if (cnt_m[i] < 15) cnt_m[i]++;
                else ovf_m[i] = 1'b1;
            end else if (!p[i] && gi) begin
                cnt_m[i]--;
            end
        end
        err_m = !ok || (err_m && !c);
    endfunction

    // Apply one cycle of stimulus; expected result is queued for the monitor.
    task automatic cyc(input logic [15:0] p, input logic [15:0] g, input logic c);
        push_i    = p;
        gnt_i     = g;
        clr_err_i = c;
        model_step(p, g, c);
        exp_q.push_back(model_out());
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        push_i    = 16'hFFFF;
        gnt_i     = 16'h0000;
        clr_err_i = 1'b0;
        model_reset();
        #1;
        check("async_req", req_o, 16'h0000);
        check("async_idle", {15'd0, idle_o}, 16'h0001);
        @(posedge clk);
        #2;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(model_out());
            @(posedge clk);
            #2;
        end
        reset  = 1'b1;
        push_i = 16'h0000;
    endtask

    // Monitor: compares every queued expectation just after the clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("req_o", req_o, e.req);
                check("ovf_o", ovf_o, e.ovf);
                check("gnt_err_o", {15'd0, gnt_err_o}, {15'd0, e.err});
                check("idle_o", {15'd0, idle_o}, {15'd0, e.idle});
            end
        end
    end

    initial begin
        int grants;
        int per_src [16];
        logic [15:0] g;
        logic [15:0] p;
        int r;
        int pick;

        model_reset();
        @(posedge clk);
        #2;
        do_reset();
        // After release with no pushes, everything stays empty.
        cyc(16'h0000, 16'h0000, 1'b0);
        cyc(16'h0000, 16'h0000, 1'b0);

        // Basic flow.
        cyc(16'h0005, 16'h0000, 1'b0);
        cyc(16'h0000, 16'h0001, 1'b0);
        cyc(16'h0000, 16'h0004, 1'b0);

        // Saturation on source 3, then drain with 15 grants.
        for (int k = 0; k < 16; k++) cyc(16'h0008, 16'h0000, 1'b0);
        for (int k = 0; k < 15; k++) cyc(16'h0000, 16'h0008, 1'b0);
        cyc(16'h0000, 16'h0000, 1'b1);

        // Push and grant together on source 7 at full and at one.
        for (int k = 0; k < 15; k++) cyc(16'h0080, 16'h0000, 1'b0);
        cyc(16'h0080, 16'h0080, 1'b0);
        for (int k = 0; k < 14; k++) cyc(16'h0000, 16'h0080, 1'b0);
        cyc(16'h0080, 16'h0080, 1'b0);
        cyc(16'h0000, 16'h0080, 1'b0);

        // Illegal grants, then clear.
        cyc(16'h0024, 16'h0000, 1'b0);
        cyc(16'h0000, 16'h0024, 1'b0);
        cyc(16'h0000, 16'h0100, 1'b0);
        cyc(16'h0000, 16'h0000, 1'b1);
        cyc(16'h0000, 16'h0004, 1'b0);
        cyc(16'h0000, 16'h0020, 1'b0);
        // Illegal grant with a concurrent error clear: set wins.
        cyc(16'h0000, 16'h0001, 1'b1);
        cyc(16'h0000, 16'h0000, 1'b1);

        // Closed loop: a lowest-index arbiter driven from the DUT's req_o.
        for (int i = 0; i < 16; i++) per_src[i] = 0;
        for (int k = 0; k < 3; k++) cyc(16'h8201, 16'h0000, 1'b0);
        grants = 0;
        for (int k = 0; k < 40; k++) begin
            g = 16'h0000;
            for (int i = 15; i >= 0; i--) if (req_o[i]) g = 16'h0001 << i;
            if (g == 16'h0000) break;
            grants++;
            for (int i = 0; i < 16; i++) if (g[i]) per_src[i]++;
            cyc(16'h0000, g, 1'b0);
        end
        check("loop_grants", grants[15:0], 16'd9);
        check("loop_src0", per_src[0][15:0], 16'd3);
        check("loop_src9", per_src[9][15:0], 16'd3);
        check("loop_src15", per_src[15][15:0], 16'd3);

        // Randomized traffic with a mix of legal and illegal grants.
        for (int k = 0; k < 400; k++) begin
            p = 16'($urandom) & 16'($urandom) & 16'($urandom);
            r = $urandom_range(0, 9);
            g = 16'h0000;
            if (r <= 5) begin
                pick = $urandom_range(0, 15);
                for (int j = 0; j < 16; j++) begin
                    if (g == 16'h0000 && cnt_m[(pick + j) % 16] != 0)
                        g = 16'h0001 << ((pick + j) % 16);
                end
            end else if (r == 7) begin
                g = 16'h0003 << $urandom_range(0, 14);
            end else if (r == 8) begin
                for (int j = 0; j < 16; j++) if (g == 16'h0000 && cnt_m[j] == 0) g = 16'h0001 << j;
            end else if (r == 9) begin
                g = 16'($urandom);
            end
            cyc(p, g, ($urandom_range(0, 15) == 0));
        end

        // Reset in the middle of traffic.
        do_reset();
        cyc(16'h0000, 16'h0000, 1'b0);

        @(posedge clk);
        #2;
        check("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
